// File: rtl/io_bank_pkg.sv
// Shared definitions for the I/O bank: register offsets, STATUS/CTRL bit positions
// and the PS/2 receiver state encoding.
package io_bank_pkg;

  localparam logic [1:0] REG_KEYDATA = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_MSCOUNT = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_AVAIL      = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERFLOW   = 2;
  localparam int STAT_PARITY_ERR = 3;

  localparam int CTRL_KBD_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rxState_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the keyboard lines, shifts start/8 data/parity/stop
// on falling ps2_clk edges and abandons a frame that stalls for RX_TIMEOUT cycles.
module ps2_rx
  import io_bank_pkg::*;
#(
  parameter int RX_TIMEOUT = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       parityOk,
  output rxState_t   rxState
);

  localparam int TW = $clog2(RX_TIMEOUT + 1);

  logic          clkS1, clkS2, clkPrev;
  logic          dataS1, dataS2;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parBit;
  logic [TW-1:0] idleCnt;
  logic          fallEdge;

  assign fallEdge = clkPrev & ~clkS2;

  // byteValid is a one-cycle strobe with no backpressure: the consumer takes the
  // byte (byteData/parityOk) in that cycle or it is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkS1     <= 1'b1;
      clkS2     <= 1'b1;
      clkPrev   <= 1'b1;
      dataS1    <= 1'b1;
      dataS2    <= 1'b1;
      rxState   <= RX_IDLE;
      bitCnt    <= 3'd0;
      shiftReg  <= 8'd0;
      parBit    <= 1'b0;
      idleCnt   <= '0;
      byteValid <= 1'b0;
      byteData  <= 8'd0;
      parityOk  <= 1'b0;
    end else begin
      clkS1     <= ps2_clk;
      clkS2     <= clkS1;
      clkPrev   <= clkS2;
      dataS1    <= ps2_data;
      dataS2    <= dataS1;
      byteValid <= 1'b0;

      if (rxState == RX_IDLE || fallEdge) idleCnt <= '0;
      else                                idleCnt <= idleCnt + TW'(1);

      if (rxState != RX_IDLE && !fallEdge && idleCnt == TW'(RX_TIMEOUT - 1)) begin
        rxState <= RX_IDLE;
      end else if (fallEdge) begin
        case (rxState)
          RX_IDLE: begin
            if (!dataS2) begin
              rxState <= RX_DATA;
              bitCnt  <= 3'd0;
            end
          end
          RX_DATA: begin
            shiftReg <= {dataS2, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
            if (bitCnt == 3'd7) rxState <= RX_PARITY;
          end
          RX_PARITY: begin
            parBit  <= dataS2;
            rxState <= RX_STOP;
          end
          RX_STOP: begin
            rxState   <= RX_IDLE;
            byteValid <= dataS2;
            byteData  <= shiftReg;
            // PS/2 uses odd parity across the data byte plus the parity bit
            parityOk  <= ^{shiftReg, parBit};
          end
          default: rxState <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/io_bank_ctrl.sv
// Memory-mapped I/O bank: PS/2 keyboard FIFO, status, millisecond counter and control.
// Define IO_BANK_PARITY_CHECK_EN to reject bad-parity frames and report parity_err.
module io_bank_ctrl
  import io_bank_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MS_DIV     = 50000,
  parameter int RX_TIMEOUT = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  memWrite,
  input  logic [10:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = ($clog2(MS_DIV) < 1) ? 1 : $clog2(MS_DIV);
  localparam logic [PW:0] CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(FIFO_DEPTH);

  logic       rxValid, rxParityOk;
  logic [7:0] rxByte;
  rxState_t   rxStateDbg;

  ps2_rx #(.RX_TIMEOUT(RX_TIMEOUT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byteValid(rxValid),
    .byteData (rxByte),
    .parityOk (rxParityOk),
    .rxState  (rxStateDbg)
  );

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [PW:0]   count;
  logic          avail, full, kbdEn, overflow, parityErr;
  logic [31:0]   msCount;
  logic [DW-1:0] divCnt;
  logic [1:0]    regSel;
  logic          pop, push, doPush, flush, overflowEvt, wrLow, stsClr;

  assign regSel = addr[1:0];
  assign avail  = (count != '0);
  assign full   = (count == CNT_FULL);
  assign wrLow  = en && memWrite[0];
  assign stsClr = wrLow && regSel == REG_STATUS;
  assign flush  = wrLow && regSel == REG_CTRL && wdata[CTRL_FLUSH];
  assign pop    = en && memWrite == 4'd0 && regSel == REG_KEYDATA && avail;

`ifdef IO_BANK_PARITY_CHECK_EN
  logic parityEvt;
  logic unusedBits;
  assign parityEvt  = rxValid && kbdEn && !rxParityOk;
  assign push       = rxValid && kbdEn && rxParityOk;
  assign unusedBits = ^{addr[10:2], rxStateDbg};

  always_ff @(posedge clk) begin
    if (rst)                          parityErr <= 1'b0;
    else if (parityEvt)               parityErr <= 1'b1;
    else if (stsClr && wdata[STAT_PARITY_ERR]) parityErr <= 1'b0;
  end
`else
  logic unusedBits;
  assign push       = rxValid && kbdEn;
  assign parityErr  = 1'b0;
  assign unusedBits = ^{addr[10:2], rxStateDbg, rxParityOk};
`endif

  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign doPush      = push && (!full || pop);
  assign overflowEvt = push && full && !pop && !flush;

  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= rxByte;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (pop)    rdPtr <= rdPtr + PW'(1);
      case ({doPush, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      kbdEn    <= 1'b1;
    end else begin
      if (overflowEvt)                         overflow <= 1'b1;
      else if (stsClr && wdata[STAT_OVERFLOW]) overflow <= 1'b0;
      if (wrLow && regSel == REG_CTRL)         kbdEn <= wdata[CTRL_KBD_EN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msCount <= 32'd0;
      divCnt  <= '0;
    end else if (en && regSel == REG_MSCOUNT && memWrite == 4'hF) begin
      msCount <= wdata;
      divCnt  <= '0;
    end else if (divCnt == DW'(MS_DIV - 1)) begin
      msCount <= msCount + 32'd1;
      divCnt  <= '0;
    end else begin
      divCnt  <= divCnt + DW'(1);
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (en) begin
      case (regSel)
        REG_KEYDATA: rdata = avail ? {24'd0, fifoMem[rdPtr]} : 32'd0;
        REG_STATUS:  rdata = {28'd0, parityErr, overflow, full, avail};
        REG_MSCOUNT: rdata = msCount;
        default:     rdata = {31'd0, kbdEn};
      endcase
    end
  end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Randomized scoreboard bench for io_bank_ctrl with a queue-based reference model.
// Honours IO_BANK_PARITY_CHECK_EN when the design is built with it.
module tb_io_bank_ctrl;
  import io_bank_pkg::*;

  localparam int DEPTH = 8;
  localparam int MSDIV = 4;
  localparam int RXTO  = 200;
  localparam int HALF  = 10;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, en, ps2_clk, ps2_data;
  logic [3:0]  memWrite;
  logic [10:0] addr;
  logic [31:0] wdata, rdata;

  io_bank_ctrl #(.FIFO_DEPTH(DEPTH), .MS_DIV(MSDIV), .RX_TIMEOUT(RXTO)) dut (
    .clk(clk), .rst(rst), .en(en), .memWrite(memWrite), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          mOverflow, mParityErr, mKbdEn;
  int unsigned loadCyc;
  logic [31:0] loadVal;

  function automatic logic [31:0] modelMs();
    return loadVal + 32'((cyc - loadCyc) / MSDIV);
  endfunction

  function automatic logic oddPar(input logic [7:0] b);
    return ~^b;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          rdActive = 0;
  int          errors = 0, checks = 0;
  logic [31:0] monE;
  string       monN;

  always @(negedge clk) begin
    if (rdActive) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: read seen with got 0x%08h but no expected entry", rdata);
      end else begin
        monE = exp_q.pop_front();
        monN = name_q.pop_front();
        if (rdata !== monE) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", monN, rdata, monE);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    rst = 1'b1; en = 1'b0; memWrite = 4'd0; ps2_clk = 1'b1; ps2_data = 1'b1;
    step(); step();
    rst = 1'b0;
    loadCyc = cyc; loadVal = 32'd0;
    mq.delete(); mOverflow = 0; mParityErr = 0; mKbdEn = 1;
  endtask

  task automatic issueRead(input logic [1:0] r, input logic [31:0] e, input string nm);
    logic [8:0] hi;
    hi = 9'($urandom_range(0, 511));
    en = 1'b1; memWrite = 4'd0; addr = {hi, r}; rdActive = 1;
    exp_q.push_back(e); name_q.push_back(nm);
    step();
    en = 1'b0; rdActive = 0;
  endtask

  task automatic busRead(input logic [1:0] r, input string nm);
    logic [31:0] e;
    case (r)
      REG_KEYDATA: begin
        e = (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0;
        if (mq.size() > 0) void'(mq.pop_front());
      end
      REG_STATUS:  e = {28'd0, mParityErr, mOverflow, mq.size() == DEPTH, mq.size() > 0};
      REG_MSCOUNT: e = modelMs();
      default:     e = {31'd0, mKbdEn};
    endcase
    issueRead(r, e, nm);
  endtask

  task automatic probeIdle();
    addr = 11'($urandom_range(0, 2047)); memWrite = 4'd0; en = 1'b0; rdActive = 1;
    exp_q.push_back(32'd0); name_q.push_back("idle_rdata");
    step();
    rdActive = 0;
  endtask

  task automatic busWrite(input logic [1:0] r, input logic [3:0] mw, input logic [31:0] d);
    logic [8:0] hi;
    hi = 9'($urandom_range(0, 511));
    en = 1'b1; memWrite = mw; addr = {hi, r}; wdata = d;
    step();
    en = 1'b0; memWrite = 4'd0;
    case (r)
      REG_STATUS: if (mw[0]) begin
        if (d[2]) mOverflow = 0;
        if (d[3]) mParityErr = 0;
      end
      REG_MSCOUNT: if (mw == 4'hF) begin loadVal = d; loadCyc = cyc; end
      REG_CTRL: if (mw[0]) begin
        mKbdEn = d[0];
        if (d[1]) mq.delete();
      end
      default: ;
    endcase
  endtask

  // nbits < 11 sends a truncated frame that the receiver must abandon
  task automatic sendFrame(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] bits;
    bit accept;
    bits = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) step();
      ps2_clk = 1'b0;
      repeat (HALF) step();
      ps2_clk = 1'b1;
    end
    repeat (HALF) step();
    ps2_data = 1'b1;
    if (nbits == 11 && stp && mKbdEn) begin
      accept = 1;
`ifdef IO_BANK_PARITY_CHECK_EN
      if (!(^{b, par})) begin accept = 0; mParityErr = 1; end
`endif
      if (accept) begin
        if (mq.size() == DEPTH) mOverflow = 1;
        else                    mq.push_back(b);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       p, s;
    int         op;
    rst = 1'b1; en = 1'b0; memWrite = 4'd0; addr = 11'd0; wdata = 32'd0;
    ps2_clk = 1'b1; ps2_data = 1'b1;

    doReset();
    busRead(REG_STATUS, "reset_status");
    busRead(REG_CTRL, "reset_ctrl");
    busRead(REG_KEYDATA, "reset_keydata");
    busRead(REG_MSCOUNT, "reset_mscount");
    probeIdle();

    // millisecond counter: 40 cycles at MS_DIV=4, then wrap from all-ones
    doReset();
    repeat (40) step();
    issueRead(REG_MSCOUNT, 32'd10, "ms_after_40");
    busWrite(REG_MSCOUNT, 4'hF, 32'hFFFF_FFFF);
    repeat (4) step();
    issueRead(REG_MSCOUNT, 32'd0, "ms_wrap");

    // single frame round trip
    sendFrame(8'h1C, oddPar(8'h1C), 1'b1, 11);
    busRead(REG_STATUS, "one_status");
    busRead(REG_KEYDATA, "one_key");
    busRead(REG_STATUS, "one_status_empty");

    // overflow: nine frames into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), oddPar(8'(i)), 1'b1, 11);
    busRead(REG_STATUS, "ovf_status");
    for (int i = 0; i < 8; i++) busRead(REG_KEYDATA, "ovf_key");
    busWrite(REG_STATUS, 4'h1, 32'h4);
    busRead(REG_STATUS, "ovf_cleared");

`ifdef IO_BANK_PARITY_CHECK_EN
    sendFrame(8'h1C, ~oddPar(8'h1C), 1'b1, 11);
    busRead(REG_STATUS, "parity_status");
    busRead(REG_KEYDATA, "parity_key");
    busWrite(REG_STATUS, 4'h1, 32'h8);
    busRead(REG_STATUS, "parity_cleared");
`endif

    // stalled partial frame must time out
    sendFrame(8'h55, 1'b0, 1'b1, 4);
    repeat (RXTO + 20) step();
    sendFrame(8'h2A, oddPar(8'h2A), 1'b1, 11);
    busRead(REG_STATUS, "to_status");
    busRead(REG_KEYDATA, "to_key");
    busRead(REG_KEYDATA, "to_key_empty");

    // reset in the middle of a frame
    sendFrame(8'h3C, 1'b0, 1'b1, 6);
    doReset();
    busRead(REG_STATUS, "midrst_status");
    busRead(REG_CTRL, "midrst_ctrl");
    sendFrame(8'hA7, oddPar(8'hA7), 1'b1, 11);
    busRead(REG_KEYDATA, "midrst_key");

    // keyboard disabled drops frames; flush empties the FIFO
    sendFrame(8'h11, oddPar(8'h11), 1'b1, 11);
    busWrite(REG_CTRL, 4'h1, 32'h0);
    sendFrame(8'h22, oddPar(8'h22), 1'b1, 11);
    busRead(REG_CTRL, "kbd_off_ctrl");
    busRead(REG_STATUS, "kbd_off_status");
    busWrite(REG_CTRL, 4'h1, 32'h3);
    busRead(REG_STATUS, "flush_status");

    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin
          b = 8'($urandom_range(0, 255));
          p = ($urandom_range(0, 7) == 0) ? ~oddPar(b) : oddPar(b);
          s = ($urandom_range(0, 9) != 0);
          sendFrame(b, p, s, 11);
        end
        3, 4: busRead(REG_KEYDATA, "rnd_key");
        5: busRead(2'($urandom_range(1, 3)), "rnd_reg");
        6: probeIdle();
        7: busWrite(REG_CTRL, 4'($urandom_range(1, 15)),
                    {30'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0)});
        8: busWrite(2'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom);
        default: busWrite(REG_MSCOUNT,
                          ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 14)),
                          ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                      : $urandom);
      endcase
    end
    while (mq.size() > 0) busRead(REG_KEYDATA, "drain_key");
    busRead(REG_STATUS, "final_status");
    busRead(REG_MSCOUNT, "final_mscount");

    repeat (3) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_bank_ctrl.md
IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, keyboard scancode FIFO depth (power of two, 2..64).
REQ-002 SHALL have parameter MS_DIV, default 50000, clk cycles per millisecond tick.
REQ-003 SHALL have parameter RX_TIMEOUT, default 5000, clk cycles allowed between PS/2 falling edges inside a frame.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: en  in  1  I/O bank select from address decode; memWrite  in  4  per-byte write enables; addr  in  11  word address.
REQ-006 SHALL have ports: wdata  in  32  write data; rdata  out  32  read data; ps2_clk  in  1  async keyboard clock; ps2_data  in  1  async keyboard data.

Function
REQ-007 SHALL select its register by addr[1:0]; addr[10:2] ignored (aliased).
REQ-008 SHALL drive rdata combinationally in the same cycle as en/addr; rdata=0 when en=0.
REQ-009 Reg 0 KEYDATA SHALL read {24'd0, FIFO head}, or 0 when empty.
REQ-010 A KEYDATA access with en=1, memWrite=0 and FIFO non-empty SHALL pop one entry at that clk edge; writes to reg 0 are ignored.
REQ-011 Reg 1 STATUS SHALL read {28'd0, parity_err, overflow, full, avail}; writing memWrite[0]=1 with wdata[2] or wdata[3] set SHALL clear the corresponding sticky bit (write-1-to-clear).
REQ-012 Reg 2 MSCOUNT SHALL be a free-running 32-bit counter incremented once every MS_DIV cycles, wrapping 0xFFFFFFFF->0; a write with memWrite=4'hF SHALL load wdata and restart the divider.
REQ-013 Reg 3 CTRL SHALL read {31'd0, kbd_en}; a write with memWrite[0]=1 SHALL set kbd_en=wdata[0], and wdata[1]=1 SHALL flush the FIFO that cycle (flush bit not stored).
REQ-014 SHALL pass ps2_clk and ps2_data through two-flop synchronizers and act on synchronized ps2_clk falling edges only.
REQ-015 Receiver FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with data=0 (start), else stay IDLE.
REQ-016 DATA SHALL shift 8 bits LSB-first, then ->PARITY; PARITY samples one bit ->STOP; STOP->IDLE always.
REQ-017 At STOP with data=1 and kbd_en=1 the byte SHALL be pushed; stop=0 or kbd_en=0 discards the frame.
REQ-018 Any non-IDLE state with no falling edge for RX_TIMEOUT cycles SHALL return to IDLE, discarding the partial frame.
REQ-019 Push when full without same-cycle pop SHALL drop the byte and set overflow; simultaneous push and pop when full SHALL succeed with no overflow.
REQ-020 Simultaneous push and pop when empty SHALL leave the byte in the FIFO; flush and push in the same cycle SHALL leave the FIFO empty.
REQ-021 full SHALL be 1 when occupancy = FIFO_DEPTH; avail SHALL be 1 when occupancy > 0.

Reset
REQ-022 On rst: FIFO empty, FSM IDLE, overflow=0, parity_err=0, MSCOUNT=0, divider=0, kbd_en=1, synchronizers=1; rst mid-frame SHALL discard the frame.

Configuration
REQ-023 With IO_BANK_PARITY_CHECK_EN defined, a frame with even parity over data+parity bit SHALL be discarded and parity_err set; without it, the parity bit is sampled and ignored and parity_err reads 0.

Structure
REQ-024 Package io_bank_pkg SHALL hold register offsets, STATUS/CTRL bit positions and the receiver state enum.
REQ-025 The PS/2 frame receiver (synchronizers, FSM, timeout) SHALL be sub-module ps2_rx, emitting a one-cycle byte-valid pulse plus parity_ok.

Verification
REQ-026 Frame 0x1C, parity 0, stop 1 -> STATUS=0x1; KEYDATA read returns 0x1C; next STATUS=0x0.
REQ-027 Nine valid frames 0x01..0x09, no reads -> STATUS=0x7; eight reads return 0x01..0x08; write STATUS wdata=0x4 -> overflow cleared.
REQ-028 With IO_BANK_PARITY_CHECK_EN: frame 0x1C, parity 1 -> FIFO empty, STATUS=0x8.
REQ-029 MS_DIV=4, reset then 40 cycles -> MSCOUNT=10; write 0xFFFFFFFF, 4 cycles -> MSCOUNT=0.
REQ-030 Start plus 3 data bits, then idle RX_TIMEOUT cycles, then full frame 0x2A -> only 0x2A in FIFO.
REQ-031 rst asserted after bit 5 of a frame -> FIFO empty, STATUS=0x0, CTRL=0x1, next full frame received correctly.
